wb_master_engine: RTL and testbench

- Synthesizable, parametrised Wishbone master that executes queued commands (write, read, wait-for-interrupt-then-status-read) on the DUT-facing Wishbone bus.
- Sits between a command source (test controller or embedded sequencer) and a Wishbone slave such as the I2CMB register block.
- Generalises the master write/read/interrupt-service sequences to arbitrary widths, adds a command FIFO and a response channel, and supports an optional ack-timeout abort.

---
 rtl/wb_master_engine_if.sv | 45 ++++
 rtl/wb_master_engine.sv | 218 +++++++++++++++++++++
 tb/tb_wb_master_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_engine_if.sv
// Bundles the command, Wishbone and response signals of wb_master_engine.
// Latency: none, this is wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side; responses are never stalled; Wishbone is paced by ack_i.
//
// master modport: the engine side (drives cmd_ready, Wishbone controls, responses, busy).
// slave modport : the environment side (command source, Wishbone slave, irq source, response sink).
interface wb_master_engine_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;
  // Wishbone bus
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  irq_i;
  // response channel and status
  logic                  rsp_valid;
  logic [1:0]            rsp_op;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_nack;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_adr, cmd_dat, ack_i, dat_i, irq_i,
    output cmd_ready, cyc_o, stb_o, we_o, adr_o, dat_o,
    output rsp_valid, rsp_op, rsp_dat, rsp_nack, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_adr, cmd_dat, ack_i, dat_i, irq_i,
    input  cmd_ready, cyc_o, stb_o, we_o, adr_o, dat_o,
    input  rsp_valid, rsp_op, rsp_dat, rsp_nack, rsp_err, busy
  );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone master executing queued WRITE / READ / WAIT_IRQ(+status read) / NOP commands.
// Latency: command accepted at edge E0 -> cyc_o high after E1; response pulse one cycle after the acked edge.
// Backpressure: cmd_ready = !full of a FIFO_DEPTH command FIFO; response channel has none.
//
// Ports: clk_i, rst_i (synchronous, active high) and bus (wb_master_engine_if.master):
//   cmd_valid/cmd_ready/cmd_op/cmd_adr/cmd_dat  command input
//   cyc_o/stb_o/we_o/adr_o/dat_o/ack_i/dat_i   Wishbone master, irq_i from the slave
//   rsp_valid/rsp_op/rsp_dat/rsp_nack/rsp_err  one-cycle response pulse, busy status
// Optional: define WB_MASTER_ACK_TIMEOUT_EN to abort a transfer not acked within TIMEOUT_CYCLES.
module wb_master_engine #(
  parameter int ADDR_WIDTH      = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int IRQ_STATUS_ADDR = 2,
  parameter int NACK_BIT        = 6,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_master_engine_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_WAIT_IRQ = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_IRQ_WAIT = 2'd2,
    S_RSP      = 2'd3
  } state_t;

  // ---------------------------------------------------------------- command FIFO
  logic [1:0]            fifo_op  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_adr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [1:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_adr;
  logic [DATA_WIDTH-1:0] head_dat;

  state_t state;

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  // Acceptance depends only on the registered full flag, so a pop in the same
  // cycle never lets a push through while full.
  assign push       = bus.cmd_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head_op    = fifo_op[rd_ptr];
  assign head_adr   = fifo_adr[rd_ptr];
  assign head_dat   = fifo_dat[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_op[wr_ptr]  <= bus.cmd_op;
      fifo_adr[wr_ptr] <= bus.cmd_adr;
      fifo_dat[wr_ptr] <= bus.cmd_dat;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------- engine FSM
  logic [1:0]            cur_op;
  logic                  cyc_q, stb_q, we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  rsp_valid_q, rsp_nack_q, rsp_err_q;
  logic [1:0]            rsp_op_q;
  logic [DATA_WIDTH-1:0] rsp_dat_q;

`ifdef WB_MASTER_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cur_op      <= OP_WRITE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= 2'd0;
      rsp_dat_q   <= '0;
      rsp_nack_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef WB_MASTER_ACK_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // rsp_valid is raised on the edge entering RSP, so it is high exactly
      // for the RSP cycle; the other response fields hold until overwritten.
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_op <= head_op;
`ifdef WB_MASTER_ACK_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            case (head_op)
              OP_WRITE, OP_READ: begin
                state <= S_REQ;
                cyc_q <= 1'b1;
                stb_q <= 1'b1;
                we_q  <= (head_op == OP_WRITE);
                adr_q <= head_adr;
                dat_q <= (head_op == OP_WRITE) ? head_dat : '0;
              end
              OP_WAIT_IRQ: state <= S_IRQ_WAIT;
              default: begin
                // reserved op: no bus cycle, empty response
                state       <= S_RSP;
                rsp_valid_q <= 1'b1;
                rsp_op_q    <= head_op;
                rsp_dat_q   <= '0;
                rsp_nack_q  <= 1'b0;
                rsp_err_q   <= 1'b0;
              end
            endcase
          end
        end

        S_IRQ_WAIT: begin
          if (bus.irq_i) begin
            state <= S_REQ;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= ADDR_WIDTH'(IRQ_STATUS_ADDR);
            dat_q <= '0;
`ifdef WB_MASTER_ACK_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        S_REQ: begin
          if (bus.ack_i) begin
            state       <= S_RSP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= cur_op;
            rsp_dat_q   <= (cur_op == OP_WRITE) ? '0 : bus.dat_i;
            rsp_nack_q  <= (cur_op == OP_WAIT_IRQ) ? bus.dat_i[NACK_BIT] : 1'b0;
            rsp_err_q   <= 1'b0;
          end
`ifdef WB_MASTER_ACK_TIMEOUT_EN
          // Count reaches TIMEOUT_CYCLES on this edge; an ack on the same edge
          // was already handled above and takes priority.
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= S_RSP;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= cur_op;
            rsp_dat_q   <= '0;
            rsp_nack_q  <= 1'b0;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        default: state <= S_IDLE;  // S_RSP: the pulse is already on the outputs
      endcase
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.cyc_o     = cyc_q;
  assign bus.stb_o     = stb_q;
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_wb_master_engine.sv
// Self-checking bench for wb_master_engine: directed scenarios plus a random command mix.
// Latency: n/a.
// Backpressure: command pushes wait on cmd_ready; the slave model acks after a programmable delay or holds off.
module tb_wb_master_engine;

  logic clk;
  logic rst;

  wb_master_engine_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

  wb_master_engine dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] dat;
    logic       nack;
    logic       err;
  } rsp_t;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
  } xfer_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  rsp_t  exp_rsp_q[$];
  xfer_t exp_bus_q[$];
  logic [7:0] model_mem [4];   // register contents as the command stream implies
  logic [7:0] slv_mem   [4];   // register contents inside the slave model
  bit    ack_hold    = 1'b0;
  int    fixed_delay = -1;
  int    last_hi     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: commands complete strictly in order, so each one's bus
  // transfer and response follow directly from the register contents so far.
  task automatic model_cmd(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat,
                           input bit aborted);
    rsp_t  r;
    xfer_t x;
    r.op = op; r.dat = 8'h00; r.nack = 1'b0; r.err = aborted;
    case (op)
      2'd0: begin
        if (!aborted) begin
          x.we = 1'b1; x.adr = adr; x.dat = dat;
          exp_bus_q.push_back(x);
          model_mem[adr] = dat;
        end
      end
      2'd1: begin
        x.we = 1'b0; x.adr = adr; x.dat = 8'h00;
        exp_bus_q.push_back(x);
        r.dat = model_mem[adr];
      end
      2'd2: begin
        x.we = 1'b0; x.adr = 2'd2; x.dat = 8'h00;
        exp_bus_q.push_back(x);
        r.dat  = model_mem[2];
        r.nack = model_mem[2][6];
      end
      default: ;
    endcase
    exp_rsp_q.push_back(r);
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] adr, input logic [7:0] dat,
                      input bit aborted);
    int budget = 200;
    bit acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    while (!acc && budget > 0) begin
      acc = bus.cmd_ready;
      @(posedge clk); #1;
      budget--;
    end
    bus.cmd_valid = 1'b0;
    if (acc) model_cmd(op, adr, dat, aborted);
    else     check("push_accept", bus.cmd_ready, 1);
  endtask

  task automatic wait_idle();
    int budget = 2000;
    while (bus.busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("idle_wait", bus.busy, 0);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Wishbone slave: 4-register file, acks after a delay, checks each transfer.
  initial begin
    int    wcnt;
    int    dly;
    bit    in_x;
    xfer_t e;
    wcnt = 0; dly = 0; in_x = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.ack_i = 1'b0;
        bus.dat_i = 8'h00;
        in_x      = 1'b0;
      end else if (bus.ack_i) begin
        bus.ack_i = 1'b0;
        bus.dat_i = 8'($urandom);
        in_x      = 1'b0;
      end else if (bus.cyc_o && bus.stb_o) begin
        if (!in_x) begin
          in_x = 1'b1;
          wcnt = 0;
          dly  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
        if (!ack_hold) begin
          if (wcnt >= dly) begin
            bus.ack_i = 1'b1;
            if (exp_bus_q.size() == 0) begin
              check("bus_unexpected", bus.cyc_o, 0);
            end else begin
              e = exp_bus_q.pop_front();
              check("bus_we",  bus.we_o,  e.we);
              check("bus_adr", bus.adr_o, e.adr);
              check("bus_dat", bus.dat_o, e.dat);
            end
            if (bus.we_o) begin
              slv_mem[bus.adr_o] = bus.dat_o;
              bus.dat_i = 8'($urandom);
            end else begin
              bus.dat_i = slv_mem[bus.adr_o];
            end
          end else begin
            wcnt++;
          end
        end
      end else begin
        in_x = 1'b0;
      end
    end
  end

  // Response checker.
  initial begin
    rsp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        check("rsp_single_cycle", prev, 0);
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_op",   bus.rsp_op,   e.op);
          check("rsp_dat",  bus.rsp_dat,  e.dat);
          check("rsp_nack", bus.rsp_nack, e.nack);
          check("rsp_err",  bus.rsp_err,  e.err);
        end
      end
      prev = bus.rsp_valid && !rst;
    end
  end

  // Bus idle values, inter-transfer gap and length of the last cyc_o burst.
  initial begin
    bit prev_cyc;
    bit seen;
    int low_cnt;
    int hi_run;
    prev_cyc = 1'b0; seen = 1'b0; low_cnt = 0; hi_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0; low_cnt = 0; hi_run = 0; prev_cyc = 1'b0;
      end else begin
        if (bus.cyc_o) begin
          if (!prev_cyc && seen) check("cyc_gap_ge2", (low_cnt >= 2), 1);
          seen    = 1'b1;
          low_cnt = 0;
          hi_run++;
        end else begin
          check("idle_bus_zero", {bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}, 0);
          if (prev_cyc) last_hi = hi_run;
          hi_run = 0;
          low_cnt++;
        end
        prev_cyc = bus.cyc_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      model_mem[i] = 8'h00;
      slv_mem[i]   = 8'h00;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_adr   = 2'd0;
    bus.cmd_dat   = 8'h00;
    bus.irq_i     = 1'b0;
    rst = 1'b1;
    tick(3);

    // reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_cyc",       bus.cyc_o, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_rsp",       {bus.rsp_valid, bus.rsp_op, bus.rsp_dat, bus.rsp_nack, bus.rsp_err}, 0);
    check("rst_bus",       {bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o}, 0);
    rst = 1'b0;
    tick(2);

    // WRITE adr=1 dat=A5, acked in the second REQ cycle
    fixed_delay = 1;
    push(2'd0, 2'd1, 8'hA5, 1'b0);
    check("wr_busy",      bus.busy, 1);
    check("wr_cyc_early", bus.cyc_o, 0);
    tick(1);
    check("wr_cyc", bus.cyc_o, 1);
    check("wr_we",  bus.we_o, 1);
    check("wr_adr", bus.adr_o, 1);
    check("wr_dat", bus.dat_o, 8'hA5);
    wait_idle();

    // READ adr=3 returning 0x3C with immediate ack
    fixed_delay = -1;
    push(2'd0, 2'd3, 8'h3C, 1'b0);
    wait_idle();
    fixed_delay = 0;
    push(2'd1, 2'd3, 8'h00, 1'b0);
    tick(1);
    check("rd_cyc", bus.cyc_o, 1);
    check("rd_we",  bus.we_o, 0);
    tick(1);
    check("rd_single_cycle", bus.cyc_o, 0);
    wait_idle();
    fixed_delay = -1;

    // FIFO full: one command stuck in REQ, four more fill the FIFO
    ack_hold = 1'b1;
    push(2'd1, 2'd1, 8'h00, 1'b0);
    tick(1);
    push(2'd0, 2'd0, 8'h11, 1'b0);
    push(2'd1, 2'd0, 8'h00, 1'b0);
    push(2'd3, 2'd2, 8'h77, 1'b0);
    push(2'd0, 2'd1, 8'h5A, 1'b0);
    check("full_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_adr   = 2'd3;
    bus.cmd_dat   = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      check("full_no_accept", bus.cmd_ready, 0);
      tick(1);
    end
    bus.cmd_valid = 1'b0;
    check("full_busy", bus.busy, 1);
    ack_hold = 1'b0;
    wait_idle();

    // WAIT_IRQ: status 0x40 (nack) then 0x80 (no nack)
    for (int pass = 0; pass < 2; pass++) begin
      push(2'd0, 2'd2, (pass == 0) ? 8'h40 : 8'h80, 1'b0);
      wait_idle();
      push(2'd2, 2'd1, 8'h00, 1'b0);
      for (int k = 0; k < 10; k++) begin
        tick(1);
        check("irq_no_bus", bus.cyc_o, 0);
      end
      bus.irq_i = 1'b1;
      wait_idle();
      bus.irq_i = 1'b0;
    end

    // irq already high when WAIT_IRQ starts
    push(2'd0, 2'd2, 8'h55, 1'b0);
    wait_idle();
    bus.irq_i = 1'b1;
    push(2'd2, 2'd0, 8'h00, 1'b0);
    tick(1);
    check("irq_pre_cyc_e1", bus.cyc_o, 0);
    tick(1);
    check("irq_pre_cyc_e2", bus.cyc_o, 1);
    check("irq_pre_adr",    bus.adr_o, 2);
    wait_idle();
    bus.irq_i = 1'b0;

    // reset in the middle of a transfer with two commands queued
    ack_hold = 1'b1;
    push(2'd1, 2'd0, 8'h00, 1'b0);
    push(2'd1, 2'd1, 8'h00, 1'b0);
    push(2'd1, 2'd3, 8'h00, 1'b0);
    check("mid_rst_cyc_before", bus.cyc_o, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_rsp_q.delete();
    exp_bus_q.delete();
    check("mid_rst_cyc",   bus.cyc_o, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_rsp",   bus.rsp_valid, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    ack_hold = 1'b0;
    tick(4);
    check("mid_rst_stays_idle", {bus.busy, bus.cyc_o}, 0);

    // random command mix against the model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      int r;
      r  = int'($urandom_range(0, 4));
      op = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : 2'd3;
      push(op, 2'($urandom), 8'($urandom), 1'b0);
      tick(int'($urandom_range(0, 2)));
    end
    wait_idle();

`ifdef WB_MASTER_ACK_TIMEOUT_EN
    // unacknowledged WRITE aborts after 16 REQ cycles, the queued READ then runs
    ack_hold = 1'b1;
    push(2'd0, 2'd1, 8'h99, 1'b1);
    push(2'd1, 2'd1, 8'h00, 1'b0);
    begin
      int budget = 100;
      while (exp_rsp_q.size() == 2 && budget > 0) begin
        tick(1);
        budget--;
      end
      if (budget == 0) check("tmo_wait", bus.rsp_valid, 1);
    end
    ack_hold = 1'b0;
    check("tmo_cyc_len", last_hi, 16);
    wait_idle();
`endif

    tick(3);
    check("leftover_rsp", exp_rsp_q.size(), 0);
    check("leftover_bus", exp_bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
